// File: rtl/snake_step_scheduler.sv
// Frame-synchronous step scheduler for the snake game: issues one step request every N frames
// at vertical-blank start and latches one button direction per step.
module snake_step_scheduler #(
    parameter int VA_END = 479,
    parameter int LINE   = 799,
    parameter int SCREEN = 524
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [1:0]  speed,
    input  logic        pause,
    input  logic        btn_up,
    input  logic        btn_right,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        step_ack,
    output logic        step_req,
    output logic [1:0]  dir,
    output logic        frame_tick,
    output logic        overrun,
    output logic [15:0] step_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam logic [9:0] BLANK_Y = 10'(VA_END + 1);
    localparam logic [9:0] END_X   = 10'(LINE);
    localparam logic [9:0] END_Y   = 10'(SCREEN);

    localparam logic [1:0] DIR_RIGHT = 2'b01;

    logic [0:0] state;
    logic [3:0] divider;
    logic [1:0] pending;
    logic       blank_start;
    logic       blank_end;
    logic       at_period;
    logic       launch;
    logic [2:0] btn_pick;

    // Frames-per-step minus one, so the divider compare needs no subtractor.
    function automatic logic [3:0] period_m1(input logic [1:0] spd);
        case (spd)
            2'd0:    period_m1 = 4'd15;
            2'd1:    period_m1 = 4'd7;
            2'd2:    period_m1 = 4'd3;
            default: period_m1 = 4'd1;
        endcase
    endfunction

    // {valid, direction} of the highest-priority pressed button.
    function automatic logic [2:0] pick_dir(input logic up, input logic right,
                                            input logic down, input logic left);
        if (up)
            pick_dir = 3'b1_00;
        else if (right)
            pick_dir = 3'b1_01;
        else if (down)
            pick_dir = 3'b1_10;
        else if (left)
            pick_dir = 3'b1_11;
        else
            pick_dir = 3'b0_00;
    endfunction

    assign blank_start = (x == 10'd0) && (y == BLANK_Y);
    assign blank_end   = (x == END_X) && (y == END_Y);
    assign at_period   = (divider >= period_m1(speed));
    assign launch      = frame_tick && !pause && at_period;
    assign btn_pick    = pick_dir(btn_up, btn_right, btn_down, btn_left);
    assign step_req    = (state == ST_REQ);

    // Stage 1: register the blank-start event into a one-cycle tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_tick <= 1'b0;
        else
            frame_tick <= blank_start;
    end

    // Stage 2: frame divider, evaluated only on unpaused ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            divider <= 4'd0;
        else if (frame_tick && !pause)
            divider <= at_period ? 4'd0 : divider + 4'd1;
    end

    // Reversal check is against the committed direction, not the pending one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= DIR_RIGHT;
        else if (btn_pick[2] && (btn_pick[1:0] != (dir ^ 2'b10)))
            pending <= btn_pick[1:0];
    end

    // Step handshake; an ack coinciding with blank end takes precedence over the abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            dir      <= DIR_RIGHT;
            overrun  <= 1'b0;
            step_cnt <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state <= ST_REQ;
                        dir   <= pending;
                    end
                end
                ST_REQ: begin
                    if (step_ack) begin
                        state    <= ST_IDLE;
                        step_cnt <= step_cnt + 16'd1;
                    end else if (blank_end) begin
                        state   <= ST_IDLE;
                        overrun <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/snake_step_scheduler.md
# snake_step_scheduler

Sequences snake game-state updates against the VGA raster. It consumes the pixel/line counters from the VGA timing generator and detects the start of vertical blanking. Every N frames (N set by a speed input) it issues a step request to the game logic with a req/ack handshake, and the step must complete before blanking ends. It also debounces-by-priority the direction buttons, rejects reversals, and commits one direction per step.

## Interface
- `VA_END`, 479, last active line; blanking starts at line VA_END+1
- `LINE`, 799, last pixel index on a line
- `SCREEN`, 524, last line index of a frame
- `clk`  in  1  pixel clock, same clock as the timing generator
- `rst`  in  1  reset, asynchronous, active-high
- `x`  in  10  current pixel counter from the timing generator
- `y`  in  10  current line counter from the timing generator
- `speed`  in  2  frames per step: 0→16, 1→8, 2→4, 3→2
- `pause`  in  1  high: freeze step scheduling
- `btn_up`, `btn_right`, `btn_down`, `btn_left`  in  1 each  direction buttons, level, synchronous to clk
- `step_ack`  in  1  game logic done with current step
- `step_req`  out  1  step request, held until ack or abort
- `dir`  out  2  committed direction: 00 up, 01 right, 10 down, 11 left
- `frame_tick`  out  1  one-cycle pulse at blanking start
- `overrun`  out  1  sticky: a step was aborted at blanking end
- `step_cnt`  out  16  completed steps, wraps 0xFFFF→0

## Operation
- Reset (async) values: step_req=0, frame_tick=0, overrun=0, step_cnt=0, dir=01, pending direction=01, divider=0, FSM=IDLE. Asserting rst mid-request drops step_req immediately. No step is counted.
- Blank-start event: (x,y)==(0,VA_END+1). Blank-end event: (x,y)==(LINE,SCREEN).
- Divider: on each frame_tick with pause=0, compare divider against period−1, where period comes from the current speed.
  - If divider ≥ period−1, set divider to 0 and launch.
  - Otherwise increment divider.
  - A speed change therefore takes effect at the next tick. If the divider is already past the new period, launch immediately.
- pause=1: the divider holds and no launch occurs. frame_tick still pulses. An in-flight request completes normally.
- Pending direction updates every cycle from the buttons.
  - Priority: up > right > down > left. Only the highest-priority pressed button is considered.
  - A press opposite to the committed `dir` is ignored.
  - No buttons pressed: pending is unchanged.
- FSM states: IDLE and REQ.
  - IDLE → REQ on launch. In the same clock edge, step_req goes to 1 and dir is loaded from pending.
  - REQ → IDLE on step_ack=1. step_req goes to 0 and step_cnt increments.
  - REQ → IDLE on the blank-end event without ack. step_req goes to 0, overrun is set to 1, and step_cnt is unchanged.
  - If ack and blank-end occur in the same cycle, ack wins: the step is counted and overrun is not set.
  - step_ack in IDLE is ignored.
- A launch while in REQ cannot occur, because the next launch is at least one frame later and blank-end forces IDLE first.
- overrun clears only on rst.

## Timing
- Blank-start sampled at edge T (x=0, y=480): frame_tick is high for exactly cycle T+1.
- Launch: step_req rises at T+2 and dir is updated at T+2.
- Ack sampled high at edge A: step_req is low and step_cnt is incremented from A+1.
- Blank-end sampled at edge E without ack: step_req is low and overrun=1 from E+1.
- Step budget: 45 lines × 800 pixels, minus 2 cycles of launch latency = 35998 cycles.
- Button direction is captured 1 cycle after the press. A press arriving in the same cycle as launch is not included in that step.
- dir is stable for the whole REQ state.

## Test plan
- Reset while step_req=1 → step_req=0 and overrun=0 asynchronously. After release: dir=01, step_cnt=0, no frame_tick until the next (0,480).
- speed=3, pause=0, ack 5 cycles after each req, run 6 frames → exactly 3 requests, each rising 2 cycles after its (0,480), step_cnt=3, overrun=0.
- speed=0, never ack → step_req rises once per 16 frames. It falls the cycle after (799,524), overrun=1 and stays 1, step_cnt=0.
- Start dir=01 (right) and press btn_left before launch → dir stays 01. Press btn_up+btn_down together, then launch → dir=00. Then press btn_down → dir stays 00.
- speed=2: assert pause after 2 frame_ticks for 10 frames, then release → first req occurs on the 2nd tick after release. frame_tick pulses every frame throughout.
- step_ack asserted exactly in the (799,524) cycle → step_cnt increments, overrun stays 0, step_req=0 next cycle.
